// File: rtl/ftdi_fifo_async245.sv
// FT232H async-245 FIFO controller: host bytes (RXF#/RD#) become an rx stream,
// and a buffered tx stream drives WR#/TXE# writes, with SIWU# flush after drain.
module ftdi_fifo_async245 #(
  parameter int RD_PULSE = 2,
  parameter int WR_PULSE = 2,
  parameter int RECOVERY = 3,
  parameter int TX_DEPTH = 16
) (
  input  logic                        clk_12mhz,
  input  logic                        reset_n,
  input  logic [7:0]                  d_in,
  output logic [7:0]                  d_out,
  output logic                        d_dir,
  input  logic                        rxf_n,
  input  logic                        txe_n,
  output logic                        rd_n,
  output logic                        wr_n,
  output logic                        siwu,
  output logic                        oe_n,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic                        tx_flush,
  output logic [$clog2(TX_DEPTH):0]   tx_level
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR,
    S_WR_HOLD,
    S_RECOVER,
    S_FLUSH
  } state_e;

  // Synchronizers for the asynchronous FTDI status lines
  logic rxf_meta_q, rxf_s_q, txe_meta_q, txe_s_q;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      rxf_meta_q <= 1'b1;
      rxf_s_q    <= 1'b1;
      txe_meta_q <= 1'b1;
      txe_s_q    <= 1'b1;
    end else begin
      rxf_meta_q <= rxf_n;
      rxf_s_q    <= rxf_meta_q;
      txe_meta_q <= txe_n;
      txe_s_q    <= txe_meta_q;
    end
  end

  // tx FIFO
  logic [7:0]    mem_q [TX_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;

  state_e        state_q;
  logic [CW-1:0] cnt_q;

  assign tx_ready = (level_q != LW'(TX_DEPTH));
  assign push     = tx_valid && tx_ready;
  assign pop      = (state_q == S_WR) && (cnt_q == '0);
  assign tx_level = level_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
  end

  // NOTE: storage array has no reset; only the pointers and level define its contents.
  always_ff @(posedge clk_12mhz) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Bus sequencer with registered pin outputs
  logic       last_rd_q, flush_pend_q;
  logic       rd_n_q, wr_n_q, siwu_q, d_dir_q, rx_valid_q;
  logic [7:0] d_out_q, rx_data_q;
  logic       rd_ok, wr_ok;

  assign rd_ok = !rxf_s_q && !rx_valid_q;
  assign wr_ok = !txe_s_q && (level_q != '0);

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_rd_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      siwu_q       <= 1'b1;
      d_dir_q      <= 1'b0;
      d_out_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
    end else begin
      if (tx_flush)                 flush_pend_q <= 1'b1;
      if (rx_valid_q && rx_ready)   rx_valid_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // On contention, serve the direction not served last time
          if (rd_ok && (!wr_ok || !last_rd_q)) begin
            state_q   <= S_RD;
            rd_n_q    <= 1'b0;
            cnt_q     <= CW'(RD_PULSE - 1);
            last_rd_q <= 1'b1;
          end else if (wr_ok) begin
            state_q   <= S_WR_SETUP;
            d_dir_q   <= 1'b1;
            d_out_q   <= mem_q[rd_ptr_q];
            last_rd_q <= 1'b0;
          end else if (flush_pend_q && (level_q == '0)) begin
            state_q <= S_FLUSH;
            siwu_q  <= 1'b0;
            cnt_q   <= CW'(1);
          end
        end
        S_RD: begin
          if (cnt_q == '0) begin
            rx_data_q  <= d_in;
            rx_valid_q <= 1'b1;
            rd_n_q     <= 1'b1;
            state_q    <= S_RECOVER;
            cnt_q      <= CW'(RECOVERY - 1);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_WR_SETUP: begin
          state_q <= S_WR;
          wr_n_q  <= 1'b0;
          cnt_q   <= CW'(WR_PULSE - 1);
        end
        S_WR: begin
          if (cnt_q == '0) begin
            wr_n_q  <= 1'b1;
            state_q <= S_WR_HOLD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_WR_HOLD: begin
          d_dir_q <= 1'b0;
          state_q <= S_RECOVER;
          cnt_q   <= CW'(RECOVERY - 1);
        end
        S_RECOVER: begin
          if (cnt_q == '0) state_q <= S_IDLE;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        S_FLUSH: begin
          if (cnt_q == '0) begin
            siwu_q       <= 1'b1;
            flush_pend_q <= 1'b0;
            state_q      <= S_RECOVER;
            cnt_q        <= CW'(RECOVERY - 1);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_n     = rd_n_q;
  assign wr_n     = wr_n_q;
  assign siwu     = siwu_q;
  assign oe_n     = 1'b1;
  assign d_dir    = d_dir_q;
  assign d_out    = d_out_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_ftdi_fifo_async245.sv
// Directed bench for ftdi_fifo_async245: reads, writes, arbitration, FIFO
// full/wrap, flush after drain and asynchronous reset during a write pulse.
module tb_ftdi_fifo_async245;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] d_in, d_out, rx_data, tx_data;
  logic       d_dir, rxf_n, txe_n, rd_n, wr_n, siwu, oe_n;
  logic       rx_valid, rx_ready, tx_valid, tx_ready, tx_flush;
  logic [4:0] tx_level;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ftdi_fifo_async245 dut (
    .clk_12mhz (clk),
    .reset_n   (reset_n),
    .d_in      (d_in),
    .d_out     (d_out),
    .d_dir     (d_dir),
    .rxf_n     (rxf_n),
    .txe_n     (txe_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .siwu      (siwu),
    .oe_n      (oe_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_flush  (tx_flush),
    .tx_level  (tx_level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return rd_n;
      1:       return wr_n;
      2:       return d_dir;
      3:       return rx_valid;
      default: return siwu;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int which, input logic val, input int budget);
    int k = 0;
    while (sel(which) !== val && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(sel(which) === val), 32'd1);
  endtask

  task automatic push(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // One complete write: setup, WR_PULSE low cycles, hold, release of d_dir
  task automatic write_seq(input logic [7:0] exp_b, input logic [4:0] exp_lvl);
    wait_sig("wr_setup_seen", 2, 1'b1, 40);
    check("setup_wr_n", 32'(wr_n), 32'd1);
    check("setup_d_out", 32'(d_out), 32'(exp_b));
    @(negedge clk);
    check("wr_low_1", 32'(wr_n), 32'd0);
    @(negedge clk);
    check("wr_low_2", 32'(wr_n), 32'd0);
    check("wr_d_out", 32'(d_out), 32'(exp_b));
    @(negedge clk);
    check("hold_wr_n", 32'(wr_n), 32'd1);
    check("hold_d_dir", 32'(d_dir), 32'd1);
    check("hold_level", 32'(tx_level), 32'(exp_lvl));
    @(negedge clk);
    check("after_d_dir", 32'(d_dir), 32'd0);
  endtask

  initial begin
    logic       prev_rd, prev_wr;
    logic [7:0] seq [8];
    logic [7:0] wb [2];
    int n, idle, min_gap, viol, lo, rdl, wrc, sl, early;

    reset_n = 1'b0; d_in = 8'h00; rxf_n = 1'b1; txe_n = 1'b1;
    rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; tx_flush = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rd_n", 32'(rd_n), 32'd1);
    check("rst_wr_n", 32'(wr_n), 32'd1);
    check("rst_siwu", 32'(siwu), 32'd1);
    check("rst_oe_n", 32'(oe_n), 32'd1);
    check("rst_d_dir", 32'(d_dir), 32'd0);
    check("rst_d_out", 32'(d_out), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_tx_level", 32'(tx_level), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1) single read of 0xA5
    rx_ready = 1'b1; d_in = 8'hA5; rxf_n = 1'b0;
    wait_sig("t1_rd_start", 0, 1'b0, 20);
    lo = 0;
    while (rd_n === 1'b0 && lo < 10) begin
      @(negedge clk);
      lo++;
    end
    rxf_n = 1'b1;
    check("t1_rd_pulse_len", 32'(lo), 32'd2);
    check("t1_rx_valid", 32'(rx_valid), 32'd1);
    check("t1_rx_data", 32'(rx_data), 32'hA5);
    @(negedge clk);
    check("t1_rx_valid_clr", 32'(rx_valid), 32'd0);
    lo = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd_n === 1'b0) lo++;
    end
    check("t1_no_second_read", 32'(lo), 32'd0);

    // 2) three queued bytes written in order
    push(8'h11); push(8'h22); push(8'h33);
    check("t2_level3", 32'(tx_level), 32'd3);
    txe_n = 1'b0;
    write_seq(8'h11, 5'd2);
    write_seq(8'h22, 5'd1);
    write_seq(8'h33, 5'd0);
    txe_n = 1'b1;
    repeat (6) @(negedge clk);

    // 3) continuous rx and tx demand: strict alternation starting with a read
    push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
    d_in = 8'h5A; rx_ready = 1'b1; rxf_n = 1'b0; txe_n = 1'b0;
    prev_rd = 1'b1; prev_wr = 1'b1; n = 0; idle = 100; min_gap = 100; viol = 0;
    for (int c = 0; c < 150 && n < 8; c++) begin
      @(negedge clk);
      if (rd_n === 1'b0 && (wr_n === 1'b0 || d_dir === 1'b1)) viol++;
      if ((rd_n === 1'b0 && prev_rd) || (wr_n === 1'b0 && prev_wr)) begin
        if (idle < min_gap) min_gap = idle;
        seq[n] = (rd_n === 1'b0) ? "R" : "W";
        n++;
      end
      if (rd_n === 1'b1 && wr_n === 1'b1) idle++;
      else idle = 0;
      prev_rd = rd_n; prev_wr = wr_n;
    end
    rxf_n = 1'b1; txe_n = 1'b1;
    check("t3_strobe_count", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t3_order_%0d", i), 32'(seq[i]), (i % 2 == 0) ? 32'("R") : 32'("W"));
    check("t3_min_gap_ge3", 32'(min_gap >= 3), 32'd1);
    check("t3_no_overlap", 32'(viol), 32'd0);
    repeat (30) @(negedge clk);

    // 4) fill 16 entries, 17th dropped, drain across the pointer wrap
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_ready_%0d", i), 32'(tx_ready), 32'd1);
      push(8'h40 + 8'(i));
    end
    check("t4_full_level", 32'(tx_level), 32'd16);
    check("t4_full_ready", 32'(tx_ready), 32'd0);
    push(8'h50);
    check("t4_drop_level", 32'(tx_level), 32'd16);
    txe_n = 1'b0;
    for (int i = 0; i < 16; i++) write_seq(8'h40 + 8'(i), 5'(15 - i));
    txe_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t4_empty_level", 32'(tx_level), 32'd0);
    check("t4_empty_ready", 32'(tx_ready), 32'd1);

    // 5) flush after drain while a held rx byte blocks reads
    rx_ready = 1'b0; d_in = 8'hC3; rxf_n = 1'b0;
    wait_sig("t5_rx_valid", 3, 1'b1, 30);
    check("t5_rx_data", 32'(rx_data), 32'hC3);
    push(8'h77); push(8'h88);
    tx_flush = 1'b1;
    @(negedge clk);
    tx_flush = 1'b0;
    txe_n = 1'b0;
    prev_wr = 1'b1; wrc = 0; rdl = 0; sl = 0; early = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rd_n === 1'b0) rdl++;
      if (wr_n === 1'b0 && prev_wr && wrc < 2) begin
        wb[wrc] = d_out;
        wrc++;
      end
      if (siwu === 1'b0) begin
        sl++;
        if (wrc < 2) early++;
      end
      if (sl > 0 && siwu === 1'b1) break;
      prev_wr = wr_n;
    end
    check("t5_write_count", 32'(wrc), 32'd2);
    check("t5_byte0", 32'(wb[0]), 32'h77);
    check("t5_byte1", 32'(wb[1]), 32'h88);
    check("t5_siwu_len", 32'(sl), 32'd2);
    check("t5_siwu_after_drain", 32'(early), 32'd0);
    check("t5_no_read", 32'(rdl), 32'd0);
    check("t5_rx_valid_held", 32'(rx_valid), 32'd1);
    check("t5_rx_data_held", 32'(rx_data), 32'hC3);
    txe_n = 1'b1; rxf_n = 1'b1; rx_ready = 1'b1;
    repeat (30) @(negedge clk);

    // 6) asynchronous reset in the middle of a write pulse
    push(8'h99);
    txe_n = 1'b0;
    wait_sig("t6_wr_low", 1, 1'b0, 40);
    #2 reset_n = 1'b0;
    #1;
    check("t6_wr_n_released", 32'(wr_n), 32'd1);
    check("t6_d_dir_released", 32'(d_dir), 32'd0);
    check("t6_level_cleared", 32'(tx_level), 32'd0);
    check("t6_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1; txe_n = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0; d_in = 8'h3C; rxf_n = 1'b0;
    wait_sig("t6_rx_valid", 3, 1'b1, 30);
    check("t6_rx_data", 32'(rx_data), 32'h3C);
    check("t6_rd_n_idle", 32'(rd_n), 32'd1);
    check("t6_wr_n_idle", 32'(wr_n), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
